// File: rtl/commit_unit.sv
// commit_unit: in-order two-wide retirement stage behind the ROB head.
// Optional difftest capture ports are built when COMMIT_DIFFTEST_EN is defined.
// Ports:
//   clock, reset          core clock; asynchronous active-high reset
//   head_*0/1, head_valid two oldest ROB entries (slot 0 is the oldest)
//   commit                combinational retire pulse back to the ROB
//   free_valid/free_preg  combinational release of old_prd to the free list
//   free_ready            free list can take two releases this cycle
//   arat_we/lrd/prd       registered architectural rename table writes
//   instret               retired-instruction count (wraps at 2^64)
//   halted, halt_pc       halt state and PC of the retired halt instruction
//   dt_*                  registered difftest view of retired slots (optional)
module commit_unit #(
   parameter logic [31:0] HALT_INSTR = 32'h00100073,
   parameter int PC_W = 32,
   parameter int LREG_W = 5,
   parameter int PREG_W = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        head_valid,
   input  logic [PC_W-1:0]   head_pc0,
   input  logic [PC_W-1:0]   head_pc1,
   input  logic [31:0]       head_instr0,
   input  logic [31:0]       head_instr1,
   input  logic [LREG_W-1:0] head_lrd0,
   input  logic [LREG_W-1:0] head_lrd1,
   input  logic [PREG_W-1:0] head_prd0,
   input  logic [PREG_W-1:0] head_prd1,
   input  logic [PREG_W-1:0] head_old_prd0,
   input  logic [PREG_W-1:0] head_old_prd1,
   input  logic              head_need_to_wb0,
   input  logic              head_need_to_wb1,
   input  logic              head_skip0,
   input  logic              head_skip1,
   output logic [1:0]        commit,
   output logic [1:0]        free_valid,
   output logic [PREG_W-1:0] free_preg0,
   output logic [PREG_W-1:0] free_preg1,
   input  logic              free_ready,
   output logic [1:0]        arat_we,
   output logic [LREG_W-1:0] arat_lrd0,
   output logic [LREG_W-1:0] arat_lrd1,
   output logic [PREG_W-1:0] arat_prd0,
   output logic [PREG_W-1:0] arat_prd1,
   output logic [63:0]       instret,
   output logic              halted,
   output logic [PC_W-1:0]   halt_pc
`ifdef COMMIT_DIFFTEST_EN
   ,
   output logic [1:0]        dt_valid,
   output logic [PC_W-1:0]   dt_pc0,
   output logic [PC_W-1:0]   dt_pc1,
   output logic [31:0]       dt_instr0,
   output logic [31:0]       dt_instr1,
   output logic              dt_skip0,
   output logic              dt_skip1,
   output logic              dt_wen0,
   output logic              dt_wen1,
   output logic [LREG_W-1:0] dt_wdest0,
   output logic [LREG_W-1:0] dt_wdest1,
   output logic [PREG_W-1:0] dt_wpreg0,
   output logic [PREG_W-1:0] dt_wpreg1
`endif
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t state, state_nx;
   logic wr0, wr1, ok0, ok1, halt0, halt1;
   // x0 writes are architectural no-ops: no release and no ARAT update
   assign wr0 = head_need_to_wb0 & (head_lrd0 != '0);
   assign wr1 = head_need_to_wb1 & (head_lrd1 != '0);
   // reset gates the combinational pulses so nothing leaks while held
   assign ok0 = (state == RUN) & ~reset & head_valid[0] & (~wr0 | free_ready);
   assign ok1 = ok0 & (head_instr0 != HALT_INSTR) & head_valid[1] & (~wr1 | free_ready);
   assign halt0 = ok0 & (head_instr0 == HALT_INSTR);
   assign halt1 = ok1 & (head_instr1 == HALT_INSTR);
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= RUN;
      else state <= state_nx;
   always_comb
      state_nx = (state == RUN && (halt0 || halt1)) ? HALTED : state;
   always_comb begin
      halted = state == HALTED;
      commit = {ok1, ok0};
      free_valid = {ok1 & wr1, ok0 & wr0};
      free_preg0 = head_old_prd0;
      free_preg1 = head_old_prd1;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         arat_we <= '0;
         arat_lrd0 <= '0;
         arat_lrd1 <= '0;
         arat_prd0 <= '0;
         arat_prd1 <= '0;
         instret <= '0;
         halt_pc <= '0;
      end else begin
         arat_we <= free_valid;
         arat_lrd0 <= head_lrd0;
         arat_lrd1 <= head_lrd1;
         arat_prd0 <= head_prd0;
         arat_prd1 <= head_prd1;
         instret <= instret + {63'd0, commit[0]} + {63'd0, commit[1]};
         if (halt0 || halt1) halt_pc <= halt0 ? head_pc0 : head_pc1;
      end
`ifdef COMMIT_DIFFTEST_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         dt_valid <= '0;
         dt_pc0 <= '0;
         dt_pc1 <= '0;
         dt_instr0 <= '0;
         dt_instr1 <= '0;
         dt_skip0 <= 1'b0;
         dt_skip1 <= 1'b0;
         dt_wen0 <= 1'b0;
         dt_wen1 <= 1'b0;
         dt_wdest0 <= '0;
         dt_wdest1 <= '0;
         dt_wpreg0 <= '0;
         dt_wpreg1 <= '0;
      end else begin
         dt_valid <= commit;
         if (commit[0]) begin
            dt_pc0 <= head_pc0;
            dt_instr0 <= head_instr0;
            dt_skip0 <= head_skip0;
            dt_wen0 <= wr0;
            dt_wdest0 <= head_lrd0;
            dt_wpreg0 <= head_prd0;
         end
         if (commit[1]) begin
            dt_pc1 <= head_pc1;
            dt_instr1 <= head_instr1;
            dt_skip1 <= head_skip1;
            dt_wen1 <= wr1;
            dt_wdest1 <= head_lrd1;
            dt_wpreg1 <= head_prd1;
         end
      end
`else
   // skip flags only matter to the difftest capture
   logic unused_skip;
   assign unused_skip = head_skip0 ^ head_skip1;
`endif
endmodule
